matrix_acc_cast: RTL and testbench



---
 rtl/matrix_acc_cast_pkg.sv | 25 ++
 rtl/matrix_acc_cast_fixed_cast_sat.sv | 41 ++++
 rtl/matrix_acc_cast.sv | 86 ++++++++
 tb/tb_matrix_acc_cast.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_acc_cast_pkg.sv
// Shared helpers for the matmul tile datapath blocks.
package matrix_acc_cast_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(
    input int in_width,
    input int depth
  );
    return in_width + clog2(depth);
  endfunction

  function automatic int flat_idx(
    input int i,
    input int w
  );
    return i * w;
  endfunction

endpackage

// File: rtl/matrix_acc_cast_fixed_cast_sat.sv
// Single-element fixed-point cast: shift (floor), then saturate.
module fixed_cast_sat #(
  parameter int IN_W      = 16,
  parameter int IN_FRAC   = 2,
  parameter int OUT_W     = 8,
  parameter int OUT_FRAC  = 1,
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic signed [IN_W-1:0] din,
  output logic [OUT_W-1:0]       dout
);

  localparam int SH_R =
    (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  localparam int SH_L =
    (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int WB =
    (IN_W + SH_L > OUT_W) ? IN_W + SH_L : OUT_W;
  localparam int WW = WB + 1;

  localparam logic signed [WW-1:0] MAXV =
    {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_A =
    {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [WW-1:0] MINV =
    SYMMETRIC ? MIN_A + WW'(1) : MIN_A;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] shf;

  // widen first so the left shift cannot lose bits
  assign ext = WW'(din);
  assign shf = (ext >>> SH_R) <<< SH_L;

  always_comb begin
    dout = shf[OUT_W-1:0];
    if (shf > MAXV) dout = MAXV[OUT_W-1:0];
    else if (shf < MINV) dout = MINV[OUT_W-1:0];
  end

endmodule

// File: rtl/matrix_acc_cast.sv
// Streaming tile accumulator with per-element fixed-point cast.
module matrix_acc_cast
  import matrix_acc_cast_pkg::*;
#(
  parameter int IN_DEPTH       = 2,
  parameter int IN_WIDTH       = 16,
  parameter int IN_FRAC_WIDTH  = 2,
  parameter int DIM0           = 2,
  parameter int DIM1           = 2,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 1,
  parameter bit SYMMETRIC      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data [DIM0*DIM1],
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_WIDTH-1:0] out_data [DIM0*DIM1],
  output logic [DIM0*DIM1*OUT_WIDTH-1:0] out_data_flat,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, IN_DEPTH);
  localparam int N = DIM0 * DIM1;
  localparam int CW = (IN_DEPTH > 1) ? clog2(IN_DEPTH) : 1;

  logic signed [ACC_WIDTH-1:0] acc [N];
  logic signed [ACC_WIDTH-1:0] ext [N];
  logic [CW-1:0] cnt;
  logic in_fire;
  logic out_fire;
  logic last;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last     = (cnt == CW'(IN_DEPTH - 1));

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ext[i] = ACC_WIDTH'($signed(in_data[i]));
    end
  end

  // accepts only happen while idle or while the result drains,
  // so a held result is never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_fire) out_valid <= 1'b0;
      if (in_fire) begin
        for (int i = 0; i < N; i++) begin
          if (cnt == '0) acc[i] <= ext[i];
          else acc[i] <= acc[i] + ext[i];
        end
        if (last) begin
          cnt       <= '0;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cast
    fixed_cast_sat #(
      .IN_W      (ACC_WIDTH),
      .IN_FRAC   (IN_FRAC_WIDTH),
      .OUT_W     (OUT_WIDTH),
      .OUT_FRAC  (OUT_FRAC_WIDTH),
      .SYMMETRIC (SYMMETRIC)
    ) u_cast (
      .din  (acc[g]),
      .dout (out_data[g])
    );
    assign out_data_flat[flat_idx(g, OUT_WIDTH) +: OUT_WIDTH] =
      out_data[g];
  end

endmodule

// File: tb/tb_matrix_acc_cast.sv
// Self-checking bench for matrix_acc_cast.
module tb_matrix_acc_cast;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: depth 2, 8b out
  logic [7:0]  d0 [4];
  logic        v0, r0, ir0, ov0;
  logic [7:0]  o0 [4];
  logic [31:0] f0;
  // u1/u2: 6b out, shared inputs
  logic [7:0]  d12 [4];
  logic        v12, r12, ir1, ir2, ov1, ov2;
  logic [5:0]  o1 [4];
  logic [5:0]  o2 [4];
  logic [23:0] f1, f2;
  // u3: depth 1
  logic [7:0]  d3 [4];
  logic        v3, r3, ir3, ov3;
  logic [7:0]  o3 [4];
  logic [31:0] f3;

  matrix_acc_cast #(
    .IN_DEPTH(2), .IN_WIDTH(8), .IN_FRAC_WIDTH(2),
    .DIM0(2), .DIM1(2), .OUT_WIDTH(8),
    .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0),
    .in_ready(ir0), .out_data(o0), .out_data_flat(f0),
    .out_valid(ov0), .out_ready(r0)
  );

  matrix_acc_cast #(
    .IN_DEPTH(2), .IN_WIDTH(8), .IN_FRAC_WIDTH(2),
    .DIM0(2), .DIM1(2), .OUT_WIDTH(6),
    .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .in_data(d12), .in_valid(v12),
    .in_ready(ir1), .out_data(o1), .out_data_flat(f1),
    .out_valid(ov1), .out_ready(r12)
  );

  matrix_acc_cast #(
    .IN_DEPTH(2), .IN_WIDTH(8), .IN_FRAC_WIDTH(2),
    .DIM0(2), .DIM1(2), .OUT_WIDTH(6),
    .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b1)
  ) u2 (
    .clk(clk), .rst(rst), .in_data(d12), .in_valid(v12),
    .in_ready(ir2), .out_data(o2), .out_data_flat(f2),
    .out_valid(ov2), .out_ready(r12)
  );

  matrix_acc_cast #(
    .IN_DEPTH(1), .IN_WIDTH(8), .IN_FRAC_WIDTH(2),
    .DIM0(2), .DIM1(2), .OUT_WIDTH(8),
    .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b0)
  ) u3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3),
    .in_ready(ir3), .out_data(o3), .out_data_flat(f3),
    .out_valid(ov3), .out_ready(r3)
  );

  typedef struct {
    int a [4];
    int b [4];
    int e [4];
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s6(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  // value/2 rounded toward -inf, clamped to 8-bit signed
  function automatic int cast_ref(input int s);
    int q;
    q = (s >= 0) ? s / 2 : -((1 - s) / 2);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send0(input int t [4]);
    int n;
    for (int i = 0; i < 4; i++) d0[i] = 8'(t[i]);
    v0 = 1'b1;
    #1;
    n = 0;
    while (!ir0 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("send0_timeout", 0, 1);
    tick();
    v0 = 1'b0;
  endtask

  task automatic chk_tile0(input string nm, input int e [4]);
    for (int i = 0; i < 4; i++) chk(nm, s8(o0[i]), e[i]);
  endtask

  vec_t vecs [4];
  int   t_a [4];
  int   t_b [4];
  int   t_e [4];
  int   x [4];
  int   msum [4];
  int   mexp [4];
  bit   mov;
  int   mcnt;
  bit   inf;

  initial begin
    vecs[0] = '{a:'{1,2,3,4}, b:'{5,6,7,8}, e:'{3,4,5,6}};
    vecs[1] = '{a:'{-3,-1,1,3}, b:'{0,0,0,0},
                e:'{-2,-1,0,1}};
    vecs[2] = '{a:'{127,127,-128,-128}, b:'{127,1,-128,-1},
                e:'{127,64,-128,-65}};
    vecs[3] = '{a:'{100,-100,50,-7}, b:'{100,-100,50,0},
                e:'{100,-100,50,-4}};

    rst = 1'b1;
    v0 = 0; r0 = 0; v12 = 0; r12 = 0; v3 = 0; r3 = 0;
    for (int i = 0; i < 4; i++) begin
      d0[i] = '0; d12[i] = '0; d3[i] = '0;
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(ov0), 0);
    chk("rst_ready", int'(ir0), 1);
    chk("rst_flat", int'(f0), 0);
    for (int i = 0; i < 4; i++) chk("rst_data", s8(o0[i]), 0);

    // table-driven two-tile groups
    r0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send0(vecs[k].a);
      chk("tbl_pre_valid", int'(ov0), 0);
      send0(vecs[k].b);
      chk("tbl_valid", int'(ov0), 1);
      chk_tile0("tbl_data", vecs[k].e);
      tick();
      chk("tbl_pop", int'(ov0), 0);
    end
    send0(vecs[0].a);
    send0(vecs[0].b);
    chk("basic_flat", int'(f0), 32'h06050403);
    tick();

    // backpressure, then simultaneous in/out handshake
    r0 = 1'b0;
    t_a = '{1,2,3,4}; t_b = '{5,6,7,8}; t_e = '{3,4,5,6};
    send0(t_a);
    send0(t_b);
    for (int i = 0; i < 4; i++) d0[i] = 8'd9;
    v0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid", int'(ov0), 1);
      chk("bp_ready", int'(ir0), 0);
      chk("bp_flat", int'(f0), 32'h06050403);
      chk_tile0("bp_data", t_e);
      tick();
    end
    for (int i = 0; i < 4; i++) d0[i] = 8'd1;
    r0 = 1'b1;
    #1;
    chk("bp_both_ready", int'(ir0), 1);
    tick();
    chk("bp_after_pop", int'(ov0), 0);
    tick();
    v0 = 1'b0;
    chk("bp_next_valid", int'(ov0), 1);
    t_e = '{1,1,1,1};
    chk_tile0("bp_next_data", t_e);
    tick();

    // reset mid-group
    t_a = '{10,10,10,10};
    send0(t_a);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ov0), 0);
    chk("mid_rst_ready", int'(ir0), 1);
    chk("mid_rst_flat", int'(f0), 0);
    t_a = '{2,2,2,2}; t_b = '{4,4,4,4}; t_e = '{3,3,3,3};
    send0(t_a);
    chk("mid_rst_pre", int'(ov0), 0);
    send0(t_b);
    chk("mid_rst_valid2", int'(ov0), 1);
    chk_tile0("mid_rst_data", t_e);
    tick();

    // saturation at 6-bit output, both limit styles
    t_a = '{127,-128,5,-5};
    t_b = '{127,-128,5,-6};
    for (int i = 0; i < 4; i++) d12[i] = 8'(t_a[i]);
    v12 = 1'b1;
    #1;
    chk("sat_ready", int'(ir1 & ir2), 1);
    tick();
    for (int i = 0; i < 4; i++) d12[i] = 8'(t_b[i]);
    tick();
    v12 = 1'b0;
    chk("sat_valid", int'(ov1 & ov2), 1);
    chk("sat_pos_a", s6(o1[0]), 31);
    chk("sat_neg_a", s6(o1[1]), -32);
    chk("sat_mid_a", s6(o1[2]), 5);
    chk("sat_fl_a", s6(o1[3]), -6);
    chk("sat_pos_s", s6(o2[0]), 31);
    chk("sat_neg_s", s6(o2[1]), -31);
    chk("sat_fl_s", s6(o2[3]), -6);
    chk("sat_flat_a", int'(f1[11:6]), 6'h20);

    // depth 1, continuous stream
    r3 = 1'b1;
    v3 = 1'b1;
    for (int i = 0; i < 4; i++) d3[i] = 8'd2;
    #1;
    chk("d1_ready0", int'(ir3), 1);
    tick();
    for (int i = 0; i < 4; i++) d3[i] = 8'd4;
    #1;
    chk("d1_valid1", int'(ov3), 1);
    chk("d1_ready1", int'(ir3), 1);
    for (int i = 0; i < 4; i++) chk("d1_data1", s8(o3[i]), 1);
    tick();
    v3 = 1'b0;
    #1;
    chk("d1_valid2", int'(ov3), 1);
    chk("d1_ready2", int'(ir3), 1);
    for (int i = 0; i < 4; i++) chk("d1_data2", s8(o3[i]), 2);
    tick();
    chk("d1_drain", int'(ov3), 0);

    // randomized traffic against a reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mov = 0;
    mcnt = 0;
    for (int i = 0; i < 4; i++) begin
      msum[i] = 0;
      mexp[i] = 0;
    end
    for (int k = 0; k < 400; k++) begin
      v0 = ($urandom_range(0, 2) != 0);
      r0 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        x[i] = int'($urandom_range(0, 255)) - 128;
        d0[i] = 8'(x[i]);
      end
      #1;
      chk("rnd_valid", int'(ov0), int'(mov));
      chk("rnd_ready", int'(ir0), int'(!mov || r0));
      if (mov) chk_tile0("rnd_data", mexp);
      inf = v0 && (!mov || r0);
      if (mov && r0) mov = 0;
      if (inf) begin
        for (int i = 0; i < 4; i++)
          msum[i] = (mcnt == 0) ? x[i] : msum[i] + x[i];
        mcnt++;
        if (mcnt == 2) begin
          mcnt = 0;
          mov = 1;
          for (int i = 0; i < 4; i++)
            mexp[i] = cast_ref(msum[i]);
        end
      end
      tick();
    end
    v0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
